ips2l_pcie_dma_bar_wr_arb: RTL

IPS2L_PCIE_DMA_BAR_WR_ARB -- requirements
Module: ips2l_pcie_dma_bar_wr_arb

---
 rtl/ips2l_pcie_dma_bar_wr_arb_pkg.sv | 17 +
 rtl/ips2l_pcie_dma_sync_fifo.sv | 52 +++++
 rtl/ips2l_pcie_dma_bar_wr_arb.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ips2l_pcie_dma_bar_wr_arb_pkg.sv
// Shared definitions for the BAR RAM write arbiter: source-select state
// encoding, beat-counter width and a saturating increment helper.
package ips2l_pcie_dma_bar_wr_arb_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DMA  = 2'd1,
    ST_LOC  = 2'd2
  } arb_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/ips2l_pcie_dma_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; the head entry is visible on
// dout_o whenever the FIFO is non-empty.
module ips2l_pcie_dma_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s, do_pop_s;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign dout_o    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push_s};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop_s};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/ips2l_pcie_dma_bar_wr_arb.sv
// BAR RAM write-port arbiter: DMA beats pass with fixed 1-cycle latency, local
// beats are buffered and slotted into cycles where the DMA stream is idle.
module ips2l_pcie_dma_bar_wr_arb
  import ips2l_pcie_dma_bar_wr_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 9,
  parameter int LOC_DEPTH    = 4,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_dma_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_dma_wr_addr,
  input  logic [127:0]          i_dma_wr_data,
  input  logic [15:0]           i_dma_wr_be,
  input  logic [1:0]            i_dma_wr_bar_hit,
  input  logic                  i_loc_wr_valid,
  output logic                  o_loc_wr_ready,
  input  logic [ADDR_WIDTH-1:0] i_loc_wr_addr,
  input  logic [127:0]          i_loc_wr_data,
  input  logic [15:0]           i_loc_wr_be,
  input  logic [1:0]            i_loc_wr_bar_hit,
  output logic                  o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
  output logic [127:0]          o_ram_wr_data,
  output logic [15:0]           o_ram_wr_be,
  output logic [1:0]            o_ram_wr_bar_hit,
  output logic                  o_loc_starve,
  output logic [CNT_W-1:0]      o_dma_beat_cnt,
  output logic [CNT_W-1:0]      o_loc_beat_cnt
);

  localparam int BEAT_W = ADDR_WIDTH + 128 + 16 + 2;
  localparam int SW     = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e state_q, state_d;

  logic                  fifo_full_s, fifo_empty_s, push_s, pop_s;
  logic [BEAT_W-1:0]     head_s;
  logic [ADDR_WIDTH-1:0] head_addr_s;
  logic [127:0]          head_data_s;
  logic [15:0]           head_be_s;
  logic [1:0]            head_bar_s;

  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [127:0]          ram_data_q, ram_data_d;
  logic [15:0]           ram_be_q, ram_be_d;
  logic [1:0]            ram_bar_q, ram_bar_d;
  logic [CNT_W-1:0]      dma_cnt_q, dma_cnt_d, loc_cnt_q, loc_cnt_d;
  logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
  logic                  starve_q, starve_d;

  // Ready depends only on FIFO occupancy, never on the DMA stream.
  assign o_loc_wr_ready = ~fifo_full_s;
  assign push_s         = i_loc_wr_valid & ~fifo_full_s;
  assign pop_s          = ~i_dma_wr_en & ~fifo_empty_s;

  ips2l_pcie_dma_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (LOC_DEPTH)
  ) u_loc_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .din_i   ({i_loc_wr_addr, i_loc_wr_data, i_loc_wr_be, i_loc_wr_bar_hit}),
    .pop_i   (pop_s),
    .dout_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign {head_addr_s, head_data_s, head_be_s, head_bar_s} = head_s;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    if (i_dma_wr_en)        state_d = ST_DMA;
    else if (!fifo_empty_s) state_d = ST_LOC;
    else                    state_d = ST_IDLE;
  end

  always_comb begin
    o_ram_wr_en = 1'b0;
    case (state_q)
      ST_DMA, ST_LOC: o_ram_wr_en = 1'b1;
      default:        o_ram_wr_en = 1'b0;
    endcase
  end

  // Payload and beat counters follow the source chosen for the next cycle.
  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_be_d   = 16'h0000;
    ram_bar_d  = ram_bar_q;
    dma_cnt_d  = dma_cnt_q;
    loc_cnt_d  = loc_cnt_q;
    case (state_d)
      ST_DMA: begin
        ram_addr_d = i_dma_wr_addr;
        ram_data_d = i_dma_wr_data;
        ram_be_d   = i_dma_wr_be;
        ram_bar_d  = i_dma_wr_bar_hit;
        dma_cnt_d  = sat_inc(dma_cnt_q);
      end
      ST_LOC: begin
        ram_addr_d = head_addr_s;
        ram_data_d = head_data_s;
        ram_be_d   = head_be_s;
        ram_bar_d  = head_bar_s;
        loc_cnt_d  = sat_inc(loc_cnt_q);
      end
      default: ram_be_d = 16'h0000;
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (pop_s)                                            starve_cnt_d = '0;
    else if (!fifo_empty_s && starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + SW'(1);
    else                                                  starve_cnt_d = starve_cnt_q;
    starve_d = starve_q | (starve_cnt_d == STARVE_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_addr_q   <= '0;
      ram_data_q   <= 128'h0;
      ram_be_q     <= 16'h0000;
      ram_bar_q    <= 2'b00;
      dma_cnt_q    <= '0;
      loc_cnt_q    <= '0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_be_q     <= ram_be_d;
      ram_bar_q    <= ram_bar_d;
      dma_cnt_q    <= dma_cnt_d;
      loc_cnt_q    <= loc_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
    end
  end

  assign o_ram_wr_addr    = ram_addr_q;
  assign o_ram_wr_data    = ram_data_q;
  assign o_ram_wr_be      = ram_be_q;
  assign o_ram_wr_bar_hit = ram_bar_q;
  assign o_loc_starve     = starve_q;
  assign o_dma_beat_cnt   = dma_cnt_q;
  assign o_loc_beat_cnt   = loc_cnt_q;

endmodule
